ex_div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops in the EX stage.

---
 rtl/ex_div_unit.sv | 131 +++++++++++++
 tb/tb_ex_div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on unsigned magnitudes, sign fix-up applied before DONE.
module ex_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [1:0]      divctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            res_ack,
    output logic            ready,
    output logic            busy,
    output logic            res_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            sel_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] result_q;

    logic            is_signed;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] special_res;

    assign is_signed   = ~divctl[0];
    assign a_mag       = (is_signed && op_a[XLEN-1]) ? (~op_a + 1'b1) : op_a;
    assign b_mag       = (is_signed && op_b[XLEN-1]) ? (~op_b + 1'b1) : op_b;
    assign div_zero    = (op_b == '0);
    assign sgn_ovf     = is_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special_res = div_zero ? (divctl[1] ? op_a : '1)
                                  : (divctl[1] ? '0 : op_a);

    // The shifted partial remainder needs XLEN+1 bits when the divisor's MSB is set;
    // one extra guard bit on the subtract turns its borrow into the compare.
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic            step_ge;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign rem_shift = {rem_q, dvd_q[XLEN-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, dsr_q};
    assign step_ge   = ~diff[XLEN+1];
    assign rem_d     = step_ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_fixed = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
    assign rem_fixed = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_rem_q <= divctl[1];
                        neg_quo_q <= is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        neg_rem_q <= is_signed && op_a[XLEN-1];
                        dvd_q     <= a_mag;
                        dsr_q     <= b_mag;
                        rem_q     <= '0;
                        count_q   <= '0;
                        if (div_zero || sgn_ovf) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Dividend register doubles as the quotient: bits enter at the LSB.
                    rem_q   <= rem_d;
                    dvd_q   <= {dvd_q[XLEN-2:0], step_ge};
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(XLEN-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= sel_rem_q ? rem_fixed : quo_fixed;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (res_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign res_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed and randomized checks of ex_div_unit against an arithmetic reference model.
module tb_ex_div_unit;
    localparam int XLEN = 32;
    localparam int NORM_EDGES = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            start;
    logic [1:0]      divctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            res_ack;
    logic            ready;
    logic            busy;
    logic            res_valid;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;

    ex_div_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .divctl(divctl),
        .op_a(op_a), .op_b(op_b), .res_ack(res_ack), .ready(ready), .busy(busy),
        .res_valid(res_valid), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics straight from the ISA rules.
    function automatic logic [XLEN-1:0] model(input logic [1:0] ctl, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, output bit special);
        int sa, sb;
        special = 1'b1;
        if (b == 0) return ctl[1] ? a : 32'hFFFF_FFFF;
        if (!ctl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return ctl[1] ? 32'd0 : a;
        special = 1'b0;
        if (ctl[0]) return ctl[1] ? (a % b) : (a / b);
        sa = a;
        sb = b;
        return ctl[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // inject: edge count at which a stray start is pulsed while busy (0 = none).
    task automatic do_op(input string tag, input logic [1:0] ctl, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int exp_edges,
                         input logic [XLEN-1:0] exp_res, input int inject, input bit start_on_ack);
        int edges;
        @(negedge clk);
        start = 1'b1; divctl = ctl; op_a = a; op_b = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        if (exp_edges > 1) check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!res_valid && edges < 100) begin
            start = (edges == inject);
            if (start) begin divctl = 2'b00; op_a = $urandom; op_b = 32'd3; end
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_lat"}, 32'(edges), 32'(exp_edges));
        check({tag, "_res"}, result, exp_res);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, result, exp_res);
        res_ack = 1'b1;
        if (start_on_ack) begin start = 1'b1; divctl = 2'b01; op_a = 32'd77; op_b = 32'd5; end
        @(posedge clk);
        @(negedge clk);
        res_ack = 1'b0;
        check({tag, "_rdy"}, {busy, ready, res_valid}, 32'b010);
        start = 1'b0;
    endtask

    initial begin
        logic [XLEN-1:0] a, b, exp, prev;
        logic [1:0]      ctl;
        bit              special, saw_valid;

        rst_n = 1'b0; flush = 1'b0; start = 1'b0; divctl = 2'b00;
        op_a = '0; op_b = '0; res_ack = 1'b0;
        #12;
        check("reset_flags", {busy, ready, res_valid}, 32'b010);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("t1_divu", 2'b01, 32'd100, 32'd7, NORM_EDGES, 32'd14, 0, 1'b0);
        do_op("t2_rem", 2'b10, 32'hFFFF_FFF9, 32'd2, NORM_EDGES, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("t2_div", 2'b00, 32'hFFFF_FFF9, 32'd2, NORM_EDGES, 32'hFFFF_FFFD, 0, 1'b0);
        do_op("t3_div0", 2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("t3_remu0", 2'b11, 32'd5, 32'd0, 1, 32'd5, 0, 1'b0);
        do_op("t4_ovf_div", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 1'b0);
        do_op("t4_ovf_rem", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0, 1'b0);
        do_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, NORM_EDGES, 32'd1, 0, 1'b0);
        do_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, NORM_EDGES, 32'h7FFF_FFFE, 0, 1'b0);

        // Flush part-way through CALC: the op must vanish without a result.
        prev = 32'h7FFF_FFFE;
        @(negedge clk);
        start = 1'b1; divctl = 2'b01; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; res_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; res_ack = 1'b0;
        check("t5_flush_flags", {busy, ready, res_valid}, 32'b010);
        check("t5_flush_result", result, prev);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
        end
        check("t5_no_valid", 32'(saw_valid), 32'd0);
        do_op("t5_divu", 2'b01, 32'd9, 32'd3, NORM_EDGES, 32'd3, 0, 1'b0);

        do_op("t6_start_calc", 2'b01, 32'd100, 32'd7, NORM_EDGES, 32'd14, 6, 1'b1);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; divctl = 2'b00; op_a = 32'd12345; op_b = 32'd17;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", {busy, ready, res_valid}, 32'b010);
        check("t6_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            ctl = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom | 32'h8000_0000;
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: b = $urandom >> $urandom_range(8, 28);
                default: b = $urandom;
            endcase
            exp = model(ctl, a, b, special);
            do_op($sformatf("rnd%0d", i), ctl, a, b, special ? 1 : NORM_EDGES, exp, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
